// File: rtl/cpu_pkg.sv
// Shared opcode encodings, phase constants, controller states and the datapath control vector.
package cpu_pkg;

    localparam int unsigned PH_WIDTH = 3;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [PH_WIDTH-1:0] PH_0 = 3'd0;
    localparam logic [PH_WIDTH-1:0] PH_1 = 3'd1;
    localparam logic [PH_WIDTH-1:0] PH_2 = 3'd2;
    localparam logic [PH_WIDTH-1:0] PH_3 = 3'd3;
    localparam logic [PH_WIDTH-1:0] PH_4 = 3'd4;
    localparam logic [PH_WIDTH-1:0] PH_5 = 3'd5;
    localparam logic [PH_WIDTH-1:0] PH_6 = 3'd6;
    localparam logic [PH_WIDTH-1:0] PH_7 = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_pc;
        logic data_e;
        logic load_ac;
        logic wr;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (phase, state, opcode, a_zero) into datapath controls,
// plus the memory wait-point and halt-request qualifiers used by the sequencer.
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 3
) (
    input  logic [PH_WIDTH-1:0] phase,
    input  state_t              state,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                a_zero,
    output ctrl_t               ctrl,
    output logic                wait_point,
    output logic                hlt_req
);

    logic [OP_WIDTH-1:0] op_hi;
    logic                is_a;
    logic                is_h;
    logic                is_z;
    logic                is_j;
    logic                is_s;

    // Opcode classes; any nonzero upper bit forces a NOP.
    always_comb begin
        is_a  = 1'b0;
        is_h  = 1'b0;
        is_z  = 1'b0;
        is_j  = 1'b0;
        is_s  = 1'b0;
        op_hi = opcode >> 3;
        if (op_hi == '0) begin
            case (opcode[2:0])
                OP_HLT:                         is_h = 1'b1;
                OP_SKZ:                         is_z = a_zero;
                OP_ADD, OP_AND, OP_XOR, OP_LDA: is_a = 1'b1;
                OP_STO:                         is_s = 1'b1;
                OP_JMP:                         is_j = 1'b1;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_HALT:  ctrl.halt = 1'b1;
            ST_FAULT: ;
            default: begin
                case (phase)
                    PH_0: ctrl.sel = 1'b1;
                    PH_1: begin
                        ctrl.sel = 1'b1;
                        ctrl.rd  = 1'b1;
                    end
                    PH_2, PH_3: begin
                        ctrl.sel   = 1'b1;
                        ctrl.rd    = 1'b1;
                        ctrl.ld_ir = 1'b1;
                    end
                    PH_4: begin
                        ctrl.inc_pc = 1'b1;
                        ctrl.halt   = is_h;
                    end
                    PH_5: ctrl.rd = is_a;
                    PH_6: begin
                        ctrl.rd     = is_a;
                        ctrl.inc_pc = is_z;
                        ctrl.ld_pc  = is_j;
                        ctrl.data_e = is_s;
                    end
                    PH_7: begin
                        ctrl.rd      = is_a;
                        ctrl.ld_pc   = is_j;
                        ctrl.data_e  = is_s;
                        ctrl.load_ac = is_a;
                        ctrl.wr      = is_s;
                    end
                endcase
            end
        endcase
    end

    assign wait_point = (phase == PH_3) || ((phase == PH_7) && (is_a || is_s));
    assign hlt_req    = (phase == PH_4) && is_h;

endmodule

// File: rtl/cpu_phase_controller.sv
// 8-phase instruction sequencer with memory wait-states, sticky timeout fault and resumable HALT.
// Optional single-step mode is built when CPU_CTRL_SINGLE_STEP_EN is defined.
module cpu_phase_controller
    import cpu_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 3,
    parameter int unsigned TO_WIDTH = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                a_zero,
    input  logic                mem_ready,
    input  logic                go,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic                step_mode,
`endif
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                load_ac,
    output logic                wr,
    output logic [2:0]          phase,
    output logic                instr_done,
    output logic                fault
);

    state_t              state_q;
    state_t              state_n;
    logic [PH_WIDTH-1:0] phase_q;
    logic [PH_WIDTH-1:0] phase_n;
    logic [TO_WIDTH-1:0] tocnt_q;
    logic [TO_WIDTH-1:0] tocnt_n;
    logic [TO_WIDTH-1:0] tocnt_inc;
    ctrl_t               ctrl;
    logic                wait_point;
    logic                hlt_req;
    logic                advance;
    logic                step_en;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    assign step_en = step_mode;
`else
    assign step_en = 1'b0;
`endif

    ctrl_decode #(
        .OP_WIDTH (OP_WIDTH)
    ) u_decode (
        .phase      (phase_q),
        .state      (state_q),
        .opcode     (opcode),
        .a_zero     (a_zero),
        .ctrl       (ctrl),
        .wait_point (wait_point),
        .hlt_req    (hlt_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            phase_q <= PH_0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            tocnt_q <= tocnt_n;
        end
    end

    // Fault outranks timeout, which outranks mem_ready/go.
    always_comb begin
        state_n   = state_q;
        phase_n   = phase_q;
        tocnt_n   = tocnt_q;
        advance   = 1'b0;
        tocnt_inc = tocnt_q + TO_WIDTH'(1);
        case (state_q)
            ST_RUN: begin
                if (wait_point && !mem_ready) begin
                    tocnt_n = tocnt_inc;
                    state_n = (tocnt_inc == TO_WIDTH'(TIMEOUT)) ? ST_FAULT : ST_WAIT;
                end else if (hlt_req) begin
                    state_n = ST_HALT;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!mem_ready) begin
                    tocnt_n = tocnt_inc;
                    if (tocnt_inc == TO_WIDTH'(TIMEOUT)) begin
                        state_n = ST_FAULT;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            ST_HALT: begin
                if (go) begin
                    state_n = ST_RUN;
                    phase_n = phase_q + PH_WIDTH'(1);
                end
            end
            ST_FAULT: ;
            default: ;
        endcase
        if (advance) begin
            tocnt_n = '0;
            state_n = ST_RUN;
            phase_n = phase_q + PH_WIDTH'(1);
            // Single-step parks at phase 0 instead of starting the next instruction.
            if ((phase_q == PH_7) && step_en) begin
                state_n = ST_HALT;
                phase_n = PH_0;
            end
        end
    end

    assign instr_done = advance && (phase_q == PH_7);
    assign fault      = (state_q == ST_FAULT);
    assign phase      = phase_q;
    assign sel        = ctrl.sel;
    assign rd         = ctrl.rd;
    assign ld_ir      = ctrl.ld_ir;
    assign inc_pc     = ctrl.inc_pc;
    assign halt       = ctrl.halt;
    assign ld_pc      = ctrl.ld_pc;
    assign data_e     = ctrl.data_e;
    assign load_ac    = ctrl.load_ac;
    assign wr         = ctrl.wr;

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Scoreboard bench for cpu_phase_controller: a behavioural model queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_cpu_phase_controller;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       a_zero;
    logic       mem_ready;
    logic       go;
    logic       step_mode = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, load_ac, wr;
    logic [2:0] phase;
    logic       instr_done;
    logic       fault;
    logic [8:0] dut_ctl;

    typedef struct {
        logic [2:0] ph;
        logic [8:0] ctl;
        logic       done;
        logic       flt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model state: current phase, stall count and mode flags.
    int m_ph;
    int m_cnt;
    bit m_wait;
    bit m_halt;
    bit m_fault;

    cpu_phase_controller #(
        .OP_WIDTH (3),
        .TO_WIDTH (4),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .a_zero     (a_zero),
        .mem_ready  (mem_ready),
        .go         (go),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .step_mode  (step_mode),
`endif
        .sel        (sel),
        .rd         (rd),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .halt       (halt),
        .ld_pc      (ld_pc),
        .data_e     (data_e),
        .load_ac    (load_ac),
        .wr         (wr),
        .phase      (phase),
        .instr_done (instr_done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, load_ac, wr};

    task automatic model_reset();
        m_ph    = 0;
        m_cnt   = 0;
        m_wait  = 1'b0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    // Expected outputs for this cycle, then the state after the coming edge.
    task automatic model_step(input int op, input bit az, input bit mr, input bit g, input bit r,
                              output exp_t e);
        bit a, h, z, j, s, gated, done;
        logic [8:0] c;
        a = (op >= 2) && (op <= 5);
        h = (op == 0);
        z = (op == 1) && az;
        j = (op == 7);
        s = (op == 6);
        c = '0;
        if (!m_fault && m_halt) begin
            c[4] = 1'b1;
        end else if (!m_fault) begin
            c[8] = (m_ph <= 3);
            c[7] = ((m_ph >= 1) && (m_ph <= 3)) || ((m_ph >= 5) && a);
            c[6] = (m_ph == 2) || (m_ph == 3);
            c[5] = (m_ph == 4) || ((m_ph == 6) && z);
            c[4] = (m_ph == 4) && h;
            c[3] = (m_ph >= 6) && j;
            c[2] = (m_ph >= 6) && s;
            c[1] = (m_ph == 7) && a;
            c[0] = (m_ph == 7) && s;
        end
        e.ph  = 3'(m_ph);
        e.ctl = c;
        e.flt = m_fault;
        done  = 1'b0;
        if (m_fault) begin
        end else if (m_halt) begin
            if (g) begin
                m_halt = 1'b0;
                m_ph   = (m_ph + 1) % 8;
            end
        end else begin
            gated = m_wait || (m_ph == 3) || ((m_ph == 7) && (a || s));
            if (gated && !mr) begin
                m_cnt++;
                if (m_cnt == TIMEOUT) begin
                    m_fault = 1'b1;
                    m_wait  = 1'b0;
                end else begin
                    m_wait = 1'b1;
                end
            end else if ((m_ph == 4) && h) begin
                m_halt = 1'b1;
            end else begin
                done   = (m_ph == 7);
                m_ph   = (m_ph + 1) % 8;
                m_cnt  = 0;
                m_wait = 1'b0;
            end
        end
        e.done = done;
        if (r) model_reset();
    endtask

    task automatic step(input int op, input bit az, input bit mr, input bit g, input bit r);
        exp_t e;
        opcode    = 3'(op);
        a_zero    = az;
        mem_ready = mr;
        go        = g;
        rst       = r;
        model_step(op, az, mr, g, r, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int op, input bit az, input bit mr, input bit g, input int n);
        for (int k = 0; k < n; k++) step(op, az, mr, g, 1'b0);
    endtask

    // Finish the current instruction (releasing any HALT) so the next one starts at phase 0.
    task automatic to_phase0(input int op);
        for (int k = 0; k < 24 && !((m_ph == 0) && !m_halt && !m_wait); k++)
            step(op, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cyc++;
            checks++;
            if (phase !== mon_e.ph) begin
                failures++;
                $display("FAIL phase cyc=%0d got=%0d want=%0d", cyc, phase, mon_e.ph);
            end
            checks++;
            if (dut_ctl !== mon_e.ctl) begin
                failures++;
                $display("FAIL ctrl cyc=%0d got=%b want=%b (sel rd ld_ir inc_pc halt ld_pc data_e load_ac wr)",
                         cyc, dut_ctl, mon_e.ctl);
            end
            checks++;
            if (instr_done !== mon_e.done) begin
                failures++;
                $display("FAIL instr_done cyc=%0d got=%b want=%b", cyc, instr_done, mon_e.done);
            end
            checks++;
            if (fault !== mon_e.flt) begin
                failures++;
                $display("FAIL fault cyc=%0d got=%b want=%b", cyc, fault, mon_e.flt);
            end
        end
    end

    initial begin
        int cur_op;
        bit cur_az;
        int pct;
        int pct_tab[4];
        pct_tab[0] = 100;
        pct_tab[1] = 75;
        pct_tab[2] = 35;
        pct_tab[3] = 4;
        pct    = 100;
        cur_op = 5;
        cur_az = 1'b0;

        rst       = 1'b1;
        opcode    = 3'd0;
        a_zero    = 1'b0;
        mem_ready = 1'b0;
        go        = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // LDA with memory always ready, go pulses outside HALT ignored.
        steps(5, 1'b0, 1'b1, 1'b0, 4);
        steps(5, 1'b0, 1'b1, 1'b1, 4);
        // ADD with three not-ready cycles at phase 3.
        steps(2, 1'b0, 1'b1, 1'b0, 3);
        steps(2, 1'b0, 1'b0, 1'b0, 3);
        steps(2, 1'b0, 1'b1, 1'b0, 5);
        // STO that never completes at phase 7: timeout fault, then reset.
        steps(6, 1'b0, 1'b1, 1'b0, 7);
        steps(6, 1'b0, 1'b0, 1'b0, 20);
        steps(6, 1'b0, 1'b1, 1'b1, 3);
        step(6, 1'b0, 1'b0, 1'b0, 1'b1);
        // HLT held, then resumed by go.
        steps(0, 1'b0, 1'b1, 1'b0, 5);
        steps(0, 1'b0, 1'b0, 1'b0, 10);
        step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        steps(0, 1'b0, 1'b0, 1'b0, 3);
        to_phase0(1);
        // SKZ with both flag values, then JMP.
        steps(1, 1'b1, 1'b1, 1'b0, 8);
        steps(1, 1'b0, 1'b1, 1'b0, 8);
        steps(7, 1'b0, 1'b1, 1'b0, 8);
        // Reset in the middle of a wait, and in HALT.
        steps(2, 1'b0, 1'b1, 1'b0, 3);
        steps(2, 1'b0, 1'b0, 1'b0, 2);
        step(2, 1'b0, 1'b0, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b1, 1'b0, 8);
        steps(0, 1'b0, 1'b1, 1'b0, 6);
        step(0, 1'b0, 1'b1, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b1, 1'b0, 8);

        // Random instruction stream with varying memory readiness.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) pct = pct_tab[$urandom_range(3, 0)];
            if ((m_ph == 0) && !m_halt && !m_wait && !m_fault) begin
                cur_op = int'($urandom_range(7, 0));
                cur_az = 1'($urandom_range(1, 0));
            end
            step(cur_op, cur_az,
                 int'($urandom_range(99, 0)) < pct,
                 $urandom_range(5, 0) == 0,
                 ($urandom_range(399, 0) == 0) || (m_fault && ($urandom_range(30, 0) == 0)));
        end

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
